ram_port_arb: RTL and testbench

- Arbitrates the single read/write port A of the shared instruction/data RAM between two requesters:
  - requester 0: core data path, behind the data address decoder.
  - requester 1: UART software-upgrade loader.
- Replaces the fixed "loader-wins" address/data mux in front of the RAM.
- Adds grant handshakes, read-data routing for the 1-cycle synchronous RAM read latency, a loader lock for bursts, and a starvation guard for the core.

---
 rtl/ram_port_arb_pkg.sv | 20 ++
 rtl/ram_port_arb_if.sv | 53 +++++
 rtl/ram_port_arb_starve_cnt.sv | 29 ++
 rtl/ram_port_arb.sv | 118 +++++++++++
 tb/tb_ram_port_arb.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_port_arb_pkg.sv
// Shared types and constants for the RAM port A arbiter.
// Requester indices map onto read-data owners through owner_of().
package ram_port_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CORE = 2'd1,
        OWN_LDR  = 2'd2
    } owner_t;

    localparam int REQ_CORE     = 0;
    localparam int REQ_LDR      = 1;
    localparam int MAX_WAIT_DEF = 15;
    localparam int WAIT_W       = 8;

    function automatic owner_t owner_of(input int idx);
        return (idx == REQ_CORE) ? OWN_CORE : OWN_LDR;
    endfunction

endpackage

// File: rtl/ram_port_arb_if.sv
// Requester and RAM-side signals of the port A arbiter, bundled as one interface.
// slave = arbiter view; master = requesters plus RAM view.
interface ram_port_arb_if #(
    parameter int XLEN         = 32,
    parameter int RAM_ADDR_LEN = 14
) ();

    logic                    m0_req;
    logic [XLEN/8-1:0]       m0_we;
    logic [RAM_ADDR_LEN-1:0] m0_addr;
    logic [XLEN-1:0]         m0_wdata;
    logic                    m0_gnt;
    logic                    m0_rvalid;
    logic [XLEN-1:0]         m0_rdata;

    logic                    m1_req;
    logic                    m1_lock;
    logic [XLEN/8-1:0]       m1_we;
    logic [RAM_ADDR_LEN-1:0] m1_addr;
    logic [XLEN-1:0]         m1_wdata;
    logic                    m1_gnt;
    logic                    m1_rvalid;
    logic [XLEN-1:0]         m1_rdata;

    logic                    ram_en;
    logic [XLEN/8-1:0]       ram_we;
    logic [RAM_ADDR_LEN-1:0] ram_addr;
    logic [XLEN-1:0]         ram_wdata;
    logic [XLEN-1:0]         ram_rdata;

    logic                    starve_flag;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        output m0_gnt, m0_rvalid, m0_rdata,
        input  m1_req, m1_lock, m1_we, m1_addr, m1_wdata,
        output m1_gnt, m1_rvalid, m1_rdata,
        output ram_en, ram_we, ram_addr, ram_wdata,
        input  ram_rdata,
        output starve_flag
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        input  m0_gnt, m0_rvalid, m0_rdata,
        output m1_req, m1_lock, m1_we, m1_addr, m1_wdata,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  ram_en, ram_we, ram_addr, ram_wdata,
        output ram_rdata,
        input  starve_flag
    );

endinterface

// File: rtl/ram_port_arb_starve_cnt.sv
// Saturating count of consecutive cycles the core was denied; flag at saturation.
// Clear has priority over increment; flag is registered state, no combinational path from inc.
module ram_port_arb_starve_cnt
    import ram_port_arb_pkg::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_starve
);

    localparam logic [WAIT_W-1:0] SAT = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != SAT)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_starve = (r_cnt == SAT);

endmodule

// File: rtl/ram_port_arb.sv
// Arbitrates RAM port A between the core (m0) and the UART loader (m1); grants are same-cycle.
// Read data returns one cycle after a read grant; a requester is held off simply by withholding gnt.
module ram_port_arb
    import ram_port_arb_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int RAM_ADDR_LEN = 14,
    parameter int MAX_WAIT     = MAX_WAIT_DEF
) (
    input  logic          clk,
    input  logic          rst,
    ram_port_arb_if.slave bus
);

    localparam int BE_W = XLEN / 8;

    logic                    w_lock_eff;
    logic                    w_gnt0;
    logic                    w_gnt1;
    logic                    w_starve;
    logic [BE_W-1:0]         w_we;
    logic [RAM_ADDR_LEN-1:0] w_addr;
    logic [XLEN-1:0]         w_wdata;

    logic                    r_lock;
    owner_t                  r_rd_owner;

    // Dropping m1_lock releases the port in the same cycle, so the core can win immediately.
    assign w_lock_eff = r_lock & bus.m1_lock;

    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (rst) begin
            w_gnt0 = 1'b0;
        end else if (w_lock_eff) begin
            w_gnt1 = bus.m1_req;
        end else if (bus.m1_req && bus.m0_req && w_starve) begin
            w_gnt0 = 1'b1;
        end else if (bus.m1_req) begin
            w_gnt1 = 1'b1;
        end else if (bus.m0_req) begin
            w_gnt0 = 1'b1;
        end
    end

    always_comb begin
        w_we    = '0;
        w_addr  = '0;
        w_wdata = '0;
        if (w_gnt0) begin
            w_we    = bus.m0_we;
            w_addr  = bus.m0_addr;
            w_wdata = bus.m0_wdata;
        end else if (w_gnt1) begin
            w_we    = bus.m1_we;
            w_addr  = bus.m1_addr;
            w_wdata = bus.m1_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_owner <= OWN_NONE;
            r_lock     <= 1'b0;
        end else begin
            if (w_gnt0 && (bus.m0_we == '0)) begin
                r_rd_owner <= owner_of(REQ_CORE);
            end else if (w_gnt1 && (bus.m1_we == '0)) begin
                r_rd_owner <= owner_of(REQ_LDR);
            end else begin
                r_rd_owner <= OWN_NONE;
            end

            if (!bus.m1_lock) begin
                r_lock <= 1'b0;
            end else if (w_gnt1) begin
                r_lock <= 1'b1;
            end
        end
    end

    ram_port_arb_starve_cnt #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve_cnt (
        .clk      (clk),
        .rst      (rst),
        .i_inc    (bus.m0_req & ~w_gnt0),
        .i_clr    (w_gnt0 | ~bus.m0_req),
        .o_starve (w_starve)
    );

    assign bus.m0_gnt      = w_gnt0;
    assign bus.m1_gnt      = w_gnt1;
    assign bus.ram_en      = w_gnt0 | w_gnt1;
    assign bus.ram_we      = w_we;
    assign bus.ram_addr    = w_addr;
    assign bus.ram_wdata   = w_wdata;

    // A read granted just before reset must not surface while reset is asserted.
    assign bus.m0_rvalid   = ~rst & (r_rd_owner == OWN_CORE);
    assign bus.m1_rvalid   = ~rst & (r_rd_owner == OWN_LDR);
    assign bus.m0_rdata    = bus.ram_rdata;
    assign bus.m1_rdata    = bus.ram_rdata;
    assign bus.starve_flag = ~rst & w_starve;

    a_one_gnt: assert property (@(posedge clk) disable iff (rst)
        !(bus.m0_gnt && bus.m1_gnt));

    a_m0_hold: assert property (@(posedge clk) disable iff (rst)
        (bus.m0_req && !bus.m0_gnt) |=>
            (!bus.m0_req || $stable({bus.m0_we, bus.m0_addr, bus.m0_wdata})));

    a_m1_hold: assert property (@(posedge clk) disable iff (rst)
        (bus.m1_req && !bus.m1_gnt) |=>
            (!bus.m1_req || $stable({bus.m1_we, bus.m1_addr, bus.m1_wdata})));

endmodule

// File: tb/tb_ram_port_arb.sv
// Directed bench for ram_port_arb: a driver queues the expected response of each cycle,
// and a negedge monitor pops and compares against the DUT outputs.
module tb_ram_port_arb;

    localparam int XLEN = 32;
    localparam int AW   = 14;
    localparam int MW   = 3;

    localparam logic [1:0] G_NO = 2'd0;
    localparam logic [1:0] G_M0 = 2'd1;
    localparam logic [1:0] G_M1 = 2'd2;

    typedef struct {
        string       nm;
        logic [1:0]  g;
        logic        st;
        logic [1:0]  rv;
        logic [31:0] rd;
        logic [3:0]  we;
        logic [13:0] addr;
        logic [31:0] wd;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ram_port_arb_if #(.XLEN(XLEN), .RAM_ADDR_LEN(AW)) ifc ();

    ram_port_arb #(
        .XLEN         (XLEN),
        .RAM_ADDR_LEN (AW),
        .MAX_WAIT     (MW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // Synchronous read-first RAM, preloaded while reset is high.
    logic [31:0] mem [0:511] = '{default: 32'h0};
    always @(posedge clk) begin
        if (rst) begin
            mem[16] <= 32'h1234_5678;
        end else if (ifc.ram_en) begin
            if (ifc.ram_we == 4'b0000) begin
                ifc.ram_rdata <= mem[ifc.ram_addr[8:0]];
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (ifc.ram_we[b]) mem[ifc.ram_addr[8:0]][8*b +: 8] <= ifc.ram_wdata[8*b +: 8];
                end
            end
        end
    end

    task automatic set_m0(input logic req, input logic [3:0] we, input logic [13:0] a,
                          input logic [31:0] d);
        ifc.m0_req   = req;
        ifc.m0_we    = we;
        ifc.m0_addr  = a;
        ifc.m0_wdata = d;
    endtask

    task automatic set_m1(input logic req, input logic lock, input logic [3:0] we,
                          input logic [13:0] a, input logic [31:0] d);
        ifc.m1_req   = req;
        ifc.m1_lock  = lock;
        ifc.m1_we    = we;
        ifc.m1_addr  = a;
        ifc.m1_wdata = d;
    endtask

    // Queue this cycle's expectation, then advance to just after the next rising edge.
    task automatic cyc(input string nm, input logic [1:0] g, input logic st,
                       input logic [1:0] rv, input logic [31:0] rd);
        exp_t e;
        e.nm = nm; e.g = g; e.st = st; e.rv = rv; e.rd = rd;
        e.we = 4'h0; e.addr = 14'h0; e.wd = 32'h0;
        if (g == G_M0) begin
            e.we = ifc.m0_we; e.addr = ifc.m0_addr; e.wd = ifc.m0_wdata;
        end else if (g == G_M1) begin
            e.we = ifc.m1_we; e.addr = ifc.m1_addr; e.wd = ifc.m1_wdata;
        end
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin : monitor
        exp_t       e;
        logic [5:0] act;
        logic [5:0] want;
        if (q.size() != 0) begin
            e    = q.pop_front();
            act  = {ifc.m0_gnt, ifc.m1_gnt, ifc.ram_en, ifc.m0_rvalid, ifc.m1_rvalid,
                    ifc.starve_flag};
            want = {e.g == G_M0, e.g == G_M1, e.g != G_NO, e.rv == G_M0, e.rv == G_M1, e.st};
            n_chk++;
            if (act !== want) begin
                n_fail++;
                $display("FAIL %s ctrl m0g/m1g/en/m0rv/m1rv/starve: got %b want %b",
                         e.nm, act, want);
            end
            n_chk++;
            if ({ifc.ram_we, ifc.ram_addr, ifc.ram_wdata} !== {e.we, e.addr, e.wd}) begin
                n_fail++;
                $display("FAIL %s ram bus we/addr/wdata: got %h/%h/%h want %h/%h/%h", e.nm,
                         ifc.ram_we, ifc.ram_addr, ifc.ram_wdata, e.we, e.addr, e.wd);
            end
            if (e.rv != G_NO) begin
                n_chk++;
                if (ifc.m0_rdata !== e.rd || ifc.m1_rdata !== e.rd) begin
                    n_fail++;
                    $display("FAIL %s rdata: got m0 %h m1 %h want %h", e.nm,
                             ifc.m0_rdata, ifc.m1_rdata, e.rd);
                end
            end
        end
    end

    initial begin : watchdog
        #50000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        set_m0(1'b1, 4'h0, 14'h010, 32'h0);
        set_m1(1'b1, 1'b0, 4'hF, 14'h100, 32'h55);
        @(posedge clk);
        #1;

        // reset holds everything idle even with both requesting
        cyc("rst_a", G_NO, 1'b0, G_NO, 32'h0);
        cyc("rst_b", G_NO, 1'b0, G_NO, 32'h0);
        rst = 1'b0;

        // contention, MAX_WAIT=3: m1,m1,m1,m0 repeating
        cyc("ct0_m1", G_M1, 1'b0, G_NO, 32'h0);
        set_m1(1'b1, 1'b0, 4'hF, 14'h101, 32'h56);
        cyc("ct1_m1", G_M1, 1'b0, G_NO, 32'h0);
        set_m1(1'b1, 1'b0, 4'hF, 14'h102, 32'h57);
        cyc("ct2_m1", G_M1, 1'b0, G_NO, 32'h0);
        set_m1(1'b1, 1'b0, 4'hF, 14'h103, 32'h58);
        cyc("ct3_m0", G_M0, 1'b1, G_NO, 32'h0);
        cyc("ct4_m1", G_M1, 1'b0, G_M0, 32'h1234_5678);
        set_m1(1'b1, 1'b0, 4'hF, 14'h104, 32'h59);
        cyc("ct5_m1", G_M1, 1'b0, G_NO, 32'h0);
        set_m1(1'b1, 1'b0, 4'hF, 14'h105, 32'h5A);
        cyc("ct6_m1", G_M1, 1'b0, G_NO, 32'h0);
        set_m1(1'b1, 1'b0, 4'hF, 14'h106, 32'h5B);
        cyc("ct7_m0", G_M0, 1'b1, G_NO, 32'h0);
        set_m0(1'b0, 4'h0, 14'h0, 32'h0);
        set_m1(1'b0, 1'b0, 4'h0, 14'h0, 32'h0);
        cyc("ct8_rv", G_NO, 1'b0, G_M0, 32'h1234_5678);

        // core read alone
        set_m0(1'b1, 4'h0, 14'h010, 32'h0);
        cyc("rd_gnt", G_M0, 1'b0, G_NO, 32'h0);
        set_m0(1'b0, 4'h0, 14'h0, 32'h0);
        cyc("rd_data", G_NO, 1'b0, G_M0, 32'h1234_5678);

        // loader byte write, then core reads the word back
        set_m1(1'b1, 1'b0, 4'b0010, 14'h040, 32'hAABB_CCDD);
        cyc("bw_gnt", G_M1, 1'b0, G_NO, 32'h0);
        set_m1(1'b0, 1'b0, 4'h0, 14'h0, 32'h0);
        cyc("bw_idle", G_NO, 1'b0, G_NO, 32'h0);
        set_m0(1'b1, 4'h0, 14'h040, 32'h0);
        cyc("bw_rd", G_M0, 1'b0, G_NO, 32'h0);
        set_m0(1'b0, 4'h0, 14'h0, 32'h0);
        cyc("bw_data", G_NO, 1'b0, G_M0, 32'h0000_CC00);

        // loader read routes rvalid to m1 only
        set_m1(1'b1, 1'b0, 4'h0, 14'h010, 32'h0);
        cyc("ld_rd", G_M1, 1'b0, G_NO, 32'h0);
        set_m1(1'b0, 1'b0, 4'h0, 14'h0, 32'h0);
        cyc("ld_data", G_NO, 1'b0, G_M1, 32'h1234_5678);

        // locked burst of 8 writes shuts the core out even when starving
        set_m0(1'b1, 4'h0, 14'h010, 32'h0);
        for (int i = 0; i < 8; i++) begin
            set_m1(1'b1, 1'b1, 4'hF, 14'(i), 32'hA0 + 32'(i));
            cyc($sformatf("burst%0d", i), G_M1, (i >= 3), G_NO, 32'h0);
        end
        set_m1(1'b0, 1'b0, 4'h0, 14'h0, 32'h0);
        cyc("unlock", G_M0, 1'b1, G_NO, 32'h0);
        set_m0(1'b0, 4'h0, 14'h0, 32'h0);
        cyc("unlock_rv", G_NO, 1'b0, G_M0, 32'h1234_5678);

        // lock held with no loader request idles the port
        set_m1(1'b1, 1'b1, 4'hF, 14'h008, 32'h11);
        cyc("lk_set", G_M1, 1'b0, G_NO, 32'h0);
        set_m1(1'b0, 1'b1, 4'h0, 14'h0, 32'h0);
        set_m0(1'b1, 4'h0, 14'h010, 32'h0);
        cyc("lk_idle0", G_NO, 1'b0, G_NO, 32'h0);
        cyc("lk_idle1", G_NO, 1'b0, G_NO, 32'h0);
        set_m1(1'b0, 1'b0, 4'h0, 14'h0, 32'h0);
        cyc("lk_drop", G_M0, 1'b0, G_NO, 32'h0);
        set_m0(1'b1, 4'h0, 14'h003, 32'h0);
        cyc("bst_rd", G_M0, 1'b0, G_M0, 32'h1234_5678);
        set_m0(1'b0, 4'h0, 14'h0, 32'h0);
        cyc("bst_data", G_NO, 1'b0, G_M0, 32'h0000_00A3);

        // reset right after a read grant suppresses its rvalid
        set_m0(1'b1, 4'h0, 14'h010, 32'h0);
        cyc("mr_gnt", G_M0, 1'b0, G_NO, 32'h0);
        set_m0(1'b0, 4'h0, 14'h0, 32'h0);
        rst = 1'b1;
        cyc("mr_rst", G_NO, 1'b0, G_NO, 32'h0);
        rst = 1'b0;
        cyc("mr_after", G_NO, 1'b0, G_NO, 32'h0);

        // reset drops the lock and the wait count
        set_m1(1'b1, 1'b1, 4'hF, 14'h009, 32'h99);
        set_m0(1'b1, 4'h0, 14'h010, 32'h0);
        cyc("lr_lock", G_M1, 1'b0, G_NO, 32'h0);
        set_m1(1'b0, 1'b1, 4'h0, 14'h0, 32'h0);
        cyc("lr_idle0", G_NO, 1'b0, G_NO, 32'h0);
        cyc("lr_idle1", G_NO, 1'b0, G_NO, 32'h0);
        cyc("lr_idle2", G_NO, 1'b1, G_NO, 32'h0);
        rst = 1'b1;
        cyc("lr_rst", G_NO, 1'b0, G_NO, 32'h0);
        rst = 1'b0;
        cyc("lr_post", G_M0, 1'b0, G_NO, 32'h0);
        set_m0(1'b0, 4'h0, 14'h0, 32'h0);
        set_m1(1'b0, 1'b0, 4'h0, 14'h0, 32'h0);
        cyc("lr_rv", G_NO, 1'b0, G_M0, 32'h1234_5678);

        for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
        #1;
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
